// File: rtl/cnn_pkg.sv
// ============================================================================
// Module : cnn_pkg
// Brief  : Shared defaults and FSM state encoding for the FC argmax stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int N_CLASS_DEF = 10;
    localparam int SCORE_W_DEF = 38;
    localparam int IDX_W_DEF   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SCAN = 2'd2,
        S_HOLD = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/max_sel.sv
// ============================================================================
// Module : max_sel
// Brief  : Combinational signed compare-and-select; 'a' wins ties.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max_sel
    import cnn_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic signed [SCORE_W-1:0] a_score,
    input  logic        [IDX_W-1:0]   a_idx,
    input  logic signed [SCORE_W-1:0] b_score,
    input  logic        [IDX_W-1:0]   b_idx,
    output logic signed [SCORE_W-1:0] win_score,
    output logic        [IDX_W-1:0]   win_idx
);

    logic w_b_wins;

    // Strict compare keeps the lower-index contender ('a') on equality.
    assign w_b_wins  = (b_score > a_score);
    assign win_score = w_b_wins ? b_score : a_score;
    assign win_idx   = w_b_wins ? b_idx   : a_idx;

endmodule

`default_nettype wire

// File: rtl/fc_argmax.sv
// ============================================================================
// Module : fc_argmax
// Brief  : Enables the FC neurons, latches their scores once all are done,
//          then serially scans the bank for the winning class.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fc_argmax
    import cnn_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_DEF,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         fc_enable,
    input  logic [N_CLASS-1:0]           fc_done,
    input  logic [N_CLASS*SCORE_W-1:0]   fc_score,
    output logic [IDX_W-1:0]             class_idx,
    output logic signed [SCORE_W-1:0]    class_score,
    output logic                         done_cls,
    input  logic                         result_ack,
    output logic                         busy
);

    localparam logic [IDX_W-1:0] C_LAST_PTR = IDX_W'(N_CLASS - 1);

    state_t r_state;
    state_t w_next;

    logic signed [SCORE_W-1:0] w_score [N_CLASS];
    logic signed [SCORE_W-1:0] r_bank  [N_CLASS];
    logic signed [SCORE_W-1:0] r_best;
    logic        [IDX_W-1:0]   r_idx;
    logic        [IDX_W-1:0]   r_ptr;
    logic        [IDX_W-1:0]   r_class_idx;
    logic signed [SCORE_W-1:0] r_class_score;
    logic                      r_done;

    logic signed [SCORE_W-1:0] w_win_score;
    logic        [IDX_W-1:0]   w_win_idx;
    logic                      w_all_done;
    logic                      w_last;

    for (genvar g = 0; g < N_CLASS; g++) begin : g_unpack
        assign w_score[g] = fc_score[g*SCORE_W +: SCORE_W];
    end

    assign w_all_done = &fc_done;
    assign w_last     = (r_ptr == C_LAST_PTR);

    max_sel #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_max_sel (
        .a_score   (r_best),
        .a_idx     (r_idx),
        .b_score   (r_bank[r_ptr]),
        .b_idx     (r_ptr),
        .win_score (w_win_score),
        .win_idx   (w_win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start)               w_next = S_RUN;
            S_RUN:  if (w_all_done)          w_next = S_SCAN;
            S_SCAN: if (w_last)              w_next = S_HOLD;
            // Ack only counts once the result is actually published.
            S_HOLD: if (r_done && result_ack) w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CLASS; i++) begin
                r_bank[i] <= '0;
            end
            r_best        <= '0;
            r_idx         <= '0;
            r_ptr         <= '0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_all_done) begin
                        for (int i = 0; i < N_CLASS; i++) begin
                            r_bank[i] <= w_score[i];
                        end
                        r_best <= w_score[0];
                        r_idx  <= '0;
                        r_ptr  <= IDX_W'(1);
                    end
                end
                S_SCAN: begin
                    r_best <= w_win_score;
                    r_idx  <= w_win_idx;
                    r_ptr  <= w_last ? '0 : r_ptr + IDX_W'(1);
                end
                S_HOLD: begin
                    // Separate result registers keep the last answer visible
                    // while the next run reuses the scan registers.
                    if (!r_done) begin
                        r_class_idx   <= r_idx;
                        r_class_score <= r_best;
                        r_done        <= 1'b1;
                    end else if (result_ack) begin
                        r_done        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fc_enable   = (r_state != S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done_cls    = r_done;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;

endmodule

`default_nettype wire

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 SHALL take parameter N_CLASS, default 10: number of fully-connected output neurons scanned.
REQ-002 SHALL take parameter SCORE_W, default 38: signed width of each FC score.
REQ-003 SHALL take parameter IDX_W, default 4: width of the class index, at least clog2(N_CLASS).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request one classification; sampled only in IDLE.
REQ-007 SHALL have port fc_enable, output, 1 bit: shared enable to all FC neuron blocks; low clears them.
REQ-008 SHALL have port fc_done, input, N_CLASS bits: per-neuron done flags.
REQ-009 SHALL have port fc_score, input, N_CLASS x SCORE_W signed: per-neuron scores, valid while the matching fc_done is high.
REQ-010 SHALL have port class_idx, output, IDX_W bits: index of the winning neuron.
REQ-011 SHALL have port class_score, output, SCORE_W signed: score of the winning neuron.
REQ-012 SHALL have port done_cls, output, 1 bit: result valid.
REQ-013 SHALL have port result_ack, input, 1 bit: consumer acknowledge.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, SCAN, HOLD.
REQ-016 IDLE: fc_enable=0; start=1 moves to RUN on the next edge.
REQ-017 RUN: fc_enable=1; on the edge where fc_done is all ones, latch all N_CLASS scores into a local bank, set best=score[0], idx=0, ptr=1, and move to SCAN.
REQ-018 RUN SHALL ignore partial fc_done patterns and wait without a timeout.
REQ-019 SCAN: one compare per cycle against the latched bank only; if bank[ptr] > best (signed, strict), update best and idx.
REQ-020 SCAN: increment ptr each cycle; after ptr=N_CLASS-1 is compared, move to HOLD.
REQ-021 SCAN SHALL take exactly N_CLASS-1 cycles.
REQ-022 Ties SHALL resolve to the lowest index.
REQ-023 fc_enable SHALL remain 1 through SCAN and HOLD so the FC blocks hold their outputs.
REQ-024 HOLD: done_cls=1 and class_idx/class_score stable; result_ack=1 returns to IDLE on the next edge, dropping fc_enable and done_cls.
REQ-025 Latency: done_cls SHALL rise N_CLASS edges after the all-done sample edge (10 for defaults).
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 result_ack SHALL be ignored outside HOLD.
REQ-028 start and result_ack high together in HOLD: the ack SHALL be honoured, start dropped, and IDLE entered for at least one cycle so the FC blocks clear.
REQ-029 A new start sampled in IDLE SHALL begin the next run on the following edge.
REQ-030 Compares SHALL be full-width SCORE_W signed; no truncation or saturation.
REQ-031 class_idx and class_score SHALL retain the last result in IDLE until the next HOLD.

Reset
REQ-032 rst=1 SHALL force IDLE, fc_enable=0, done_cls=0, busy=0, class_idx=0, class_score=0, ptr=0, and the score bank to 0.
REQ-033 rst mid-RUN or mid-SCAN SHALL abort with no result; the FC blocks clear via fc_enable=0.
REQ-034 rst SHALL take priority over start and result_ack.

Structure
REQ-035 N_CLASS, SCORE_W, IDX_W defaults and the state enum SHALL live in shared package cnn_pkg.
REQ-036 The signed compare-and-select step SHALL be sub-module max_sel (two scores and two indices in; winner score and index out; combinational).
REQ-037 No multipliers SHALL be used; scores SHALL be registered once in the bank.

Verification
REQ-038 Scores {5,-3,100,7,0,2,99,-1,1,3}, done all at cycle 4 -> done_cls at cycle 14, class_idx=2, class_score=100.
REQ-039 All scores -2^37 except index 9 = -2^37+1 -> class_idx=9, verifying signed full-width compare.
REQ-040 Scores with 42 at indices 3 and 8, others lower -> class_idx=3 (tie to lowest).
REQ-041 fc_done=0x1FF held 20 cycles, then 0x3FF -> FSM stays in RUN and latches only after all ten are high; score changes during SCAN leave the result unaffected.
REQ-042 rst pulsed at cycle 3 of SCAN -> next edge: IDLE, fc_enable=0, done_cls=0, class_idx=0; a fresh start completes normally.
REQ-043 start and result_ack high together in HOLD -> one IDLE cycle with fc_enable=0, no new run; start on the following cycle begins a new run.
